// File: rtl/debug_host_bridge_if.sv
// Host-link and b16 bus signal bundle for the debug host bridge.
// Latency: none (wires only).
// Backpressure: rx uses valid/ready, tx uses valid/ready, bus completes on bus_ack.
interface debug_host_bridge_if #(
    parameter int l = 16
);
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [l-1:1] bus_addr;
    logic [l-1:0] bus_wdata;
    logic         bus_r;
    logic [1:0]   bus_w;
    logic [l-1:0] bus_rdata;
    logic         bus_ack;

    // Bridge side: consumes rx bytes, produces tx bytes, masters the bus.
    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output bus_addr, bus_wdata, bus_r, bus_w,
        input  bus_rdata, bus_ack
    );

    // Environment side: host link endpoints plus the bus slave.
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  bus_addr, bus_wdata, bus_r, bus_w,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/debug_host_bridge.sv
// Debug host bridge: parses host byte frames ('W'/'R') into single b16 bus accesses and replies.
// Latency: first reply byte one cycle after the bus ack or timeout; '?' one cycle after the bad byte.
// Backpressure: rx_ready low from bus access to end of reply; tx_ready low stalls indefinitely.
// Optional macro DBG_HOST_AUTOINC_EN: held auto-incrementing address plus short 'w'/'r' commands.
module debug_host_bridge #(
    parameter int l       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    debug_host_bridge_if.master host,
    output logic                busy
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        BUS,
        TX_HI,
        TX_LO,
        TX_ACK,
        TX_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [l-1:1]  addr_q, addr_d;
    logic [l-1:0]  wdata_q, wdata_d;
    logic [l-1:0]  rdata_q, rdata_d;
    logic          wr_q, wr_d;
    logic [7:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rx_rdy;
    logic          rx_hs;
    logic          tx_vld;
    logic          in_bus;
    logic          timed_out;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    tx_dat;

    assign rx_rdy    = (state_q == IDLE)    || (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO);
    assign rx_hs     = rx_rdy && host.rx_valid;
    assign tx_vld    = (state_q == TX_HI) || (state_q == TX_LO) ||
                       (state_q == TX_ACK) || (state_q == TX_ERR);
    assign in_bus    = (state_q == BUS);
    assign cnt_inc   = cnt_q + 1'b1;
    // The limit is hit on the cycle whose increment would reach TIMEOUT; 0 disables it.
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    assign host.rx_ready  = rx_rdy;
    assign host.tx_valid  = tx_vld;
    assign host.tx_data   = tx_dat;
    assign host.bus_addr  = addr_q;
    assign host.bus_wdata = wdata_q;
    assign host.bus_r     = in_bus && !wr_q;
    assign host.bus_w     = {2{in_bus && wr_q}};
    assign busy           = (state_q != IDLE);

    // Reply byte selection; idle link shows zero.
    always_comb begin
        tx_dat = 8'h00;
        case (state_q)
            TX_HI:   tx_dat = rdata_q[l-1 -: 8];
            TX_LO:   tx_dat = rdata_q[7:0];
            TX_ACK:  tx_dat = 8'h4B;
            TX_ERR:  tx_dat = err_q;
            default: tx_dat = 8'h00;
        endcase
    end

    // Frame parsing, bus access sequencing and reply sequencing.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rx_hs) begin
                    case (host.rx_data)
                        8'h57: begin
                            wr_d    = 1'b1;
                            state_d = ADDR_HI;
                        end
                        8'h52: begin
                            wr_d    = 1'b0;
                            state_d = ADDR_HI;
                        end
`ifdef DBG_HOST_AUTOINC_EN
                        8'h77: begin
                            wr_d    = 1'b1;
                            state_d = DATA_HI;
                        end
                        8'h72: begin
                            wr_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = BUS;
                        end
`endif
                        default: begin
                            err_d   = 8'h3F;
                            state_d = TX_ERR;
                        end
                    endcase
                end
            end
            ADDR_HI: begin
                if (rx_hs) begin
                    addr_d[l-1 -: 8] = host.rx_data;
                    state_d          = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (rx_hs) begin
                    // Byte address LSB is dropped: the bus is word addressed.
                    addr_d[7:1] = host.rx_data[7:1];
                    if (wr_q) begin
                        state_d = DATA_HI;
                    end else begin
                        cnt_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            DATA_HI: begin
                if (rx_hs) begin
                    wdata_d[l-1 -: 8] = host.rx_data;
                    state_d           = DATA_LO;
                end
            end
            DATA_LO: begin
                if (rx_hs) begin
                    wdata_d[7:0] = host.rx_data;
                    cnt_d        = '0;
                    state_d      = BUS;
                end
            end
            BUS: begin
                // An ack on the limit cycle still counts as a normal completion.
                if (host.bus_ack) begin
                    if (!wr_q) begin
                        rdata_d = host.bus_rdata;
                    end
`ifdef DBG_HOST_AUTOINC_EN
                    addr_d = addr_q + 1'b1;
`endif
                    state_d = wr_q ? TX_ACK : TX_HI;
                end else if (timed_out) begin
                    cnt_d   = cnt_inc;
                    err_d   = 8'h21;
                    state_d = TX_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_HI: begin
                if (host.tx_ready) begin
                    state_d = TX_LO;
                end
            end
            TX_LO, TX_ACK, TX_ERR: begin
                if (host.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial frame or access silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
